expr_ctrl: RTL and testbench

EXPR_CTRL -- requirements
Module: expr_ctrl

---
 rtl/expr_ctrl.sv | 142 ++++++++++++++
 tb/tb_expr_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/expr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : expr_ctrl
// Purpose  : Streaming evaluator for single-digit "+"/"*" expressions ending in "=".
// Revision : 1.0 - initial release
// ============================================================================
module expr_ctrl #(
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [7:0]    in,
    output logic          in_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] result,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OPND = 3'd1,
        S_OPER = 3'd2,
        S_ERR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] c_OP_NONE = 2'd0;
    localparam logic [1:0] c_OP_ADD  = 2'd1;
    localparam logic [1:0] c_OP_MUL  = 2'd2;

    localparam logic [7:0] c_CH_ZERO = 8'h30;
    localparam logic [7:0] c_CH_NINE = 8'h39;
    localparam logic [7:0] c_CH_PLUS = 8'h2B;
    localparam logic [7:0] c_CH_STAR = 8'h2A;
    localparam logic [7:0] c_CH_EQ   = 8'h3D;

    state_t        r_state;
    logic [RW-1:0] r_sum;
    logic [RW-1:0] r_prod;
    logic [RW-1:0] r_result;
    logic [1:0]    r_op;
    logic          r_err;
    logic          r_in_ready;
    logic          r_res_valid;

    logic          w_accept;
    logic          w_is_digit;
    logic          w_is_op;
    logic          w_is_eq;
    logic [7:0]    w_dig8;
    logic [RW-1:0] w_digit;
    logic [RW-1:0] w_mul;
    logic [RW-1:0] w_total;

    assign w_accept   = in_valid & r_in_ready;
    assign w_is_digit = (in >= c_CH_ZERO) && (in <= c_CH_NINE);
    assign w_is_op    = (in == c_CH_PLUS) || (in == c_CH_STAR);
    assign w_is_eq    = (in == c_CH_EQ);
    assign w_dig8     = in - c_CH_ZERO;
    assign w_digit    = RW'(w_dig8[3:0]);
    // Sum holds completed terms, prod the term still open, so "*" binds tighter.
    assign w_mul      = r_prod * w_digit;
    assign w_total    = r_sum + r_prod;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_sum       <= '0;
            r_prod      <= '0;
            r_op        <= c_OP_NONE;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_res_valid <= 1'b0;
        end else if (r_state == S_DONE) begin
            if (res_ready) begin
                r_state     <= S_IDLE;
                r_in_ready  <= 1'b1;
                r_res_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (w_is_eq) begin
                // Every state reaches DONE on "=": only a complete operand yields a value.
                r_state     <= S_DONE;
                r_in_ready  <= 1'b0;
                r_res_valid <= 1'b1;
                if (r_state == S_OPND) begin
                    r_result <= w_total;
                    r_err    <= 1'b0;
                end else begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_digit) begin
                            r_prod  <= w_digit;
                            r_sum   <= '0;
                            r_op    <= c_OP_NONE;
                            r_state <= S_OPND;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                    S_OPND: begin
                        if (w_is_op) begin
                            r_op    <= (in == c_CH_STAR) ? c_OP_MUL : c_OP_ADD;
                            r_state <= S_OPER;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                    S_OPER: begin
                        if (w_is_digit) begin
                            if (r_op == c_OP_MUL) begin
                                r_prod <= w_mul;
                            end else begin
                                r_sum  <= w_total;
                                r_prod <= w_digit;
                            end
                            r_state <= S_OPND;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                    S_ERR:   r_state <= S_ERR;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign result    = r_result;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_expr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_ctrl
// Purpose  : Directed and random expressions checked against a term/product model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_expr_ctrl;

    localparam int c_RW  = 8;
    localparam int c_MOD = 256;

    logic            clk = 1'b0;
    logic            clr;
    logic            in_valid;
    logic [7:0]      in;
    logic            in_ready;
    logic            res_valid;
    logic            res_ready;
    logic [c_RW-1:0] result;
    logic            err;

    int checks = 0;
    int errors = 0;

    expr_ctrl #(.RW(c_RW)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in        (in),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: validate the token pattern, then sum the products of "+"-separated terms.
    function automatic void model(input byte q[$], output int r, output bit e);
        int  n;
        int  acc;
        int  term;
        bit  ok;
        n  = q.size() - 1;
        ok = (n >= 1) && (n % 2 == 1);
        for (int i = 0; ok && i < n; i++) begin
            if (i % 2 == 0) ok = (q[i] >= "0") && (q[i] <= "9");
            else            ok = (q[i] == "+") || (q[i] == "*");
        end
        if (!ok) begin
            r = 0;
            e = 1'b1;
            return;
        end
        acc  = 0;
        term = q[0] - "0";
        for (int i = 1; i < n; i += 2) begin
            if (q[i] == "*") term = (term * (q[i+1] - "0")) % c_MOD;
            else begin
                acc  = (acc + term) % c_MOD;
                term = q[i+1] - "0";
            end
        end
        r = (acc + term) % c_MOD;
        e = 1'b0;
    endfunction

    task automatic send_char(input byte c, input int gap);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) check("in_ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in       = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in       = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_q(input string tag, input byte q[$], input int hold, input int gap);
        int r;
        bit e;
        model(q, r, e);
        foreach (q[i]) send_char(q[i], (i == q.size() - 1) ? 0 : gap);
        check({tag, ".res_valid"}, res_valid, 1);
        check({tag, ".result"},    result, r);
        check({tag, ".err"},       err, e);
        check({tag, ".in_ready"},  in_ready, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"},  res_valid, 1);
            check({tag, ".hold_result"}, result, r);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, ".released"}, res_valid, 0);
        check({tag, ".ready_back"}, in_ready, 1);
    endtask

    task automatic run_str(input string tag, input string s, input int hold, input int gap);
        byte q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        run_q(tag, q, hold, gap);
    endtask

    initial begin
        byte rq[$];
        byte alpha;
        int  nops;
        clr       = 1'b1;
        in_valid  = 1'b0;
        in        = 8'h00;
        res_ready = 1'b0;
        #2;
        check("reset.res_valid", res_valid, 0);
        check("reset.in_ready",  in_ready, 1);
        check("reset.result",    result, 0);
        check("reset.err",       err, 0);
        @(posedge clk); #1;
        clr = 1'b0;

        run_str("add_mul",   "3+4*5=",   0, 0);
        run_str("chain",     "2*3*4+1=", 0, 0);
        run_str("wrap",      "9*9*9=",   0, 0);
        run_str("double_op", "3++4=",    0, 0);
        run_str("eq_only",   "=",        0, 0);
        run_str("hold",      "5=",       5, 0);
        run_str("toggle",    "7*8=",     0, 2);
        run_str("trail_op",  "4+=",      0, 0);
        run_str("bad_char",  "1+x2*3=",  1, 1);

        // Reset in the middle of an expression discards partial state.
        send_char("6", 0);
        send_char("*", 0);
        #2 clr = 1'b1;
        #2 clr = 1'b0;
        check("clr_mid.res_valid", res_valid, 0);
        check("clr_mid.in_ready",  in_ready, 1);
        run_str("after_clr", "1+1=", 0, 0);

        // Reset while a result is pending drops it.
        send_char("9", 0);
        send_char("=", 0);
        check("pend.res_valid", res_valid, 1);
        #2 clr = 1'b1;
        #2 clr = 1'b0;
        check("clr_done.res_valid", res_valid, 0);
        check("clr_done.result",    result, 0);
        check("clr_done.in_ready",  in_ready, 1);

        // A character offered on the releasing edge must be ignored.
        send_char("8", 0);
        send_char("=", 0);
        in_valid  = 1'b1;
        in        = "5";
        res_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        run_str("no_accept_in_done", "=", 0, 0);

        for (int k = 0; k < 40; k++) begin
            rq.delete();
            nops = $urandom_range(0, 5);
            for (int i = 0; i <= nops; i++) begin
                rq.push_back(byte'("0" + $urandom_range(0, 9)));
                if (i != nops) rq.push_back(($urandom_range(0, 1) == 1) ? "*" : "+");
            end
            if ($urandom_range(0, 3) == 0) begin
                alpha = ($urandom_range(0, 1) == 1) ? "a" : "+";
                rq[$urandom_range(0, rq.size() - 1)] = alpha;
            end
            rq.push_back("=");
            run_q($sformatf("rand%0d", k), rq, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
